booth_mul_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one multi-cycle radix-4 Booth multiplier among NREQ requesters inside a PE cluster. It accepts signed operand pairs over per-requester valid/ready handshakes and drives the multiplier's hold-valid/done protocol. It returns each product with the requester index over a single valid/ready response port. A watchdog guards against a multiplier that never signals done.

---
 rtl/booth_mul_arbiter_pkg.sv | 20 ++
 rtl/booth_mul_arbiter_if.sv | 42 ++++
 rtl/booth_mul_arbiter_rr_pick.sv | 33 +++
 rtl/booth_mul_arbiter.sv | 141 ++++++++++++++
 tb/tb_booth_mul_arbiter.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/booth_mul_arbiter_pkg.sv
// Shared types and defaults for the Booth multiplier arbiter and its picker.
package booth_mul_arbiter_pkg;

  localparam int unsigned NREQ_DEF  = 4;
  localparam int unsigned WIDTH_DEF = 16;

  // Index width for n requesters; a single requester still needs one bit.
  function automatic int unsigned id_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned ID_W = id_w(NREQ_DEF);

  typedef enum logic [1:0] {
    StArb,
    StRun,
    StRsp
  } state_e;

endpackage

// File: rtl/booth_mul_arbiter_if.sv
// Request, response and multiplier-side signals of the Booth multiplier arbiter.
interface booth_mul_arbiter_if
  import booth_mul_arbiter_pkg::*;
#(
  parameter int unsigned NREQ    = NREQ_DEF,
  parameter int unsigned WIDTH_M = WIDTH_DEF,
  parameter int unsigned WIDTH_R = WIDTH_DEF
) ();

  localparam int unsigned IdW = id_w(NREQ);
  localparam int unsigned PW  = WIDTH_M + WIDTH_R;

  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*WIDTH_M-1:0] req_a;
  logic [NREQ*WIDTH_R-1:0] req_b;

  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [IdW-1:0]          rsp_id;
  logic [PW-1:0]           rsp_data;
  logic                    rsp_err;

  logic                    mul_vld;
  logic [WIDTH_M-1:0]      mul_a;
  logic [WIDTH_R-1:0]      mul_b;
  logic [PW-1:0]           mul_out;
  logic                    mul_done;

  // Arbiter side.
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, mul_out, mul_done,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, mul_vld, mul_a, mul_b
  );

  // Requesters, consumer and multiplier side.
  modport master (
    output req_valid, req_a, req_b, rsp_ready, mul_out, mul_done,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, mul_vld, mul_a, mul_b
  );

endinterface

// File: rtl/booth_mul_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module booth_mul_arbiter_rr_pick
  import booth_mul_arbiter_pkg::*;
#(
  parameter int unsigned N = NREQ_DEF,
  localparam int unsigned IdxW = id_w(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [IdxW-1:0] idx,
  output logic            any
);

  logic [IdxW-1:0] j;

  // Scan N positions starting at ptr; the first hit wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      j = IdxW'((32'(ptr) + k) % N);
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/booth_mul_arbiter.sv
// Shares one multi-cycle Booth multiplier among NREQ requesters, with a done watchdog.
module booth_mul_arbiter
  import booth_mul_arbiter_pkg::*;
#(
  parameter int unsigned NREQ    = NREQ_DEF,
  parameter int unsigned WIDTH_M = WIDTH_DEF,
  parameter int unsigned WIDTH_R = WIDTH_DEF,
  parameter int unsigned TIMEOUT = 2 * WIDTH_R
) (
  input  logic                clk,
  input  logic                rstn,
  booth_mul_arbiter_if.slave  bus,
  output logic                err_sticky
);

  localparam int unsigned IdW = id_w(NREQ);
  localparam int unsigned PW  = WIDTH_M + WIDTH_R;
  localparam int unsigned WdW = $clog2(TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [IdW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0]     id_q, id_d;
  logic [WIDTH_M-1:0] mul_a_q, mul_a_d;
  logic [WIDTH_R-1:0] mul_b_q, mul_b_d;
  logic               mul_vld_q, mul_vld_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [PW-1:0]      rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;
  logic               err_q, err_d;
  logic [WdW-1:0]     wdog_q, wdog_d;

  logic [NREQ-1:0]    pick_gnt;
  logic [IdW-1:0]     pick_idx;
  logic               pick_any;

  booth_mul_arbiter_rr_pick #(
    .N (NREQ)
  ) u_rr_pick (
    .req (bus.req_valid),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Next-state, operand latching, watchdog and the combinational grant.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    id_d          = id_q;
    mul_a_d       = mul_a_q;
    mul_b_d       = mul_b_q;
    mul_vld_d     = mul_vld_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    rsp_err_d     = rsp_err_q;
    err_d         = err_q;
    wdog_d        = wdog_q;
    bus.req_ready = '0;

    unique case (state_q)
      StArb: begin
        // No grant may be offered while reset is asserted.
        bus.req_ready = rstn ? pick_gnt : '0;
        if (pick_any) begin
          mul_a_d   = bus.req_a[pick_idx * WIDTH_M +: WIDTH_M];
          mul_b_d   = bus.req_b[pick_idx * WIDTH_R +: WIDTH_R];
          id_d      = pick_idx;
          mul_vld_d = 1'b1;
          rr_ptr_d  = (32'(pick_idx) == NREQ - 1) ? '0 : pick_idx + 1'b1;
          wdog_d    = '0;
          state_d   = StRun;
        end
      end
      StRun: begin
        wdog_d = wdog_q + 1'b1;
        // A real completion beats the watchdog in the same cycle.
        if (bus.mul_done) begin
          rsp_data_d  = bus.mul_out;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          mul_vld_d   = 1'b0;
          state_d     = StRsp;
        end else if (wdog_q == WdW'(TIMEOUT - 1)) begin
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          err_d       = 1'b1;
          rsp_valid_d = 1'b1;
          mul_vld_d   = 1'b0;
          state_d     = StRsp;
        end
      end
      StRsp: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StArb;
        end
      end
      default: state_d = StArb;
    endcase
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StArb;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_vld_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      err_q       <= 1'b0;
      wdog_q      <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      mul_vld_q   <= mul_vld_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      err_q       <= err_d;
      wdog_q      <= wdog_d;
    end
  end

  assign bus.mul_vld   = mul_vld_q;
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign err_sticky    = err_q;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed plus randomized bench for booth_mul_arbiter with a behavioural multiplier stub.
module tb_booth_mul_arbiter;
  import booth_mul_arbiter_pkg::*;

  localparam int unsigned NREQ = 4;
  localparam int unsigned WM   = 16;
  localparam int unsigned WR   = 16;
  localparam int unsigned TO   = 2 * WR;
  localparam int LAT_OK = WR + 4;  // accept cycle to first rsp_valid cycle
  localparam int LAT_TO = TO + 1;  // TO run cycles, then response

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic err_sticky;

  booth_mul_arbiter_if #(.NREQ(NREQ), .WIDTH_M(WM), .WIDTH_R(WR)) bus ();

  booth_mul_arbiter #(
    .NREQ    (NREQ),
    .WIDTH_M (WM),
    .WIDTH_R (WR),
    .TIMEOUT (TO)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .bus        (bus),
    .err_sticky (err_sticky)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier stub: done appears WR+2 cycles after it first samples mul_vld, held until idle.
  logic stub_dead = 1'b0;
  logic spur      = 1'b0;
  int   mcnt      = 0;
  logic signed [31:0] sa, sb;
  always @(posedge clk) begin
    if (!bus.mul_vld) mcnt <= 0;
    else if (mcnt < 1000) mcnt <= mcnt + 1;
  end
  assign sa           = {{16{bus.mul_a[15]}}, bus.mul_a};
  assign sb           = {{16{bus.mul_b[15]}}, bus.mul_b};
  assign bus.mul_out  = sa * sb;
  assign bus.mul_done = (bus.mul_vld && !stub_dead && mcnt >= int'(WR + 2)) || spur;

  // Reference state.
  logic [WM-1:0] op_a [NREQ];
  logic [WR-1:0] op_b [NREQ];
  int rr      = 0;
  bit err_exp = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] v);
    int i;
    for (int k = 0; k < int'(NREQ); k++) begin
      i = (rr + k) % NREQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [31:0] prod(input logic [WM-1:0] a, input logic [WR-1:0] b);
    int ia, ib;
    ia = $signed(a);
    ib = $signed(b);
    return 32'(ia * ib);
  endfunction

  task automatic pack_ops();
    for (int i = 0; i < int'(NREQ); i++) begin
      bus.req_a[i*WM +: WM] = op_a[i];
      bus.req_b[i*WR +: WR] = op_b[i];
    end
  endtask

  // One transaction; entered and left at negedge+1 of an ARB cycle.
  task automatic txn(input logic [NREQ-1:0] valids, input int hold, input bit to,
                     output int t_acc, output int w);
    logic [WM-1:0] ea;
    logic [WR-1:0] eb;
    logic [31:0]   ed;
    bit busy_ok, stable;
    int t0, lim;
    bus.req_valid = valids;
    bus.rsp_ready = (hold == 0);
    #1;
    w = pick(valids);
    chk("grant", 64'(bus.req_ready), 64'(1) << w);
    ea    = op_a[w];
    eb    = op_b[w];
    ed    = to ? 32'h0 : prod(ea, eb);
    t0    = cyc;
    t_acc = t0;
    rr    = (w + 1) % NREQ;
    @(negedge clk); #1;
    // The winner may present fresh operands once accepted.
    op_a[w] = 16'($urandom);
    op_b[w] = 16'($urandom);
    pack_ops();
    busy_ok = 1'b1;
    lim = 0;
    while (!bus.rsp_valid && lim < 80) begin
      if (!(bus.mul_vld === 1'b1 && bus.req_ready === '0 && bus.mul_a === ea &&
            bus.mul_b === eb))
        busy_ok = 1'b0;
      @(negedge clk); #1;
      lim++;
    end
    chk("busy_hold", 64'(busy_ok), 64'(1));
    chk("latency", 64'(cyc - t0), 64'(to ? LAT_TO : LAT_OK));
    chk("rsp_id", 64'(bus.rsp_id), 64'(w));
    chk("rsp_data", 64'(bus.rsp_data), 64'(ed));
    chk("rsp_err", 64'(bus.rsp_err), 64'(to));
    chk("mul_vld_in_rsp", 64'(bus.mul_vld), 64'(0));
    if (to) err_exp = 1'b1;
    chk("err_sticky", 64'(err_sticky), 64'(err_exp));
    if (hold > 0) begin
      stable = 1'b1;
      for (int c = 0; c < hold; c++) begin
        spur = c[0];  // spurious done pulses must be ignored in RSP
        @(negedge clk); #1;
        if (!(bus.rsp_valid === 1'b1 && bus.rsp_id === 2'(w) && bus.rsp_data === ed &&
              bus.rsp_err === to && bus.mul_vld === 1'b0 && bus.req_ready === '0))
          stable = 1'b0;
      end
      spur = 1'b0;
      chk("backpressure_stable", 64'(stable), 64'(1));
      bus.rsp_ready = 1'b1;
    end
    @(negedge clk); #1;
    chk("rsp_cleared", 64'(bus.rsp_valid), 64'(0));
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t_prev, t_now, w;
    bit idle_ok;

    for (int i = 0; i < int'(NREQ); i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    pack_ops();
    bus.req_valid = '1;  // grants must stay off while in reset
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_mul_vld", 64'(bus.mul_vld), 64'(0));
    chk("rst_mul_a", 64'(bus.mul_a), 64'(0));
    chk("rst_mul_b", 64'(bus.mul_b), 64'(0));
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("rst_rsp_id", 64'(bus.rsp_id), 64'(0));
    chk("rst_rsp_data", 64'(bus.rsp_data), 64'(0));
    chk("rst_rsp_err", 64'(bus.rsp_err), 64'(0));
    chk("rst_err_sticky", 64'(err_sticky), 64'(0));
    chk("rst_req_ready", 64'(bus.req_ready), 64'(0));
    bus.req_valid = '0;
    rstn = 1'b1;
    @(negedge clk); #1;
    chk("idle_no_ready", 64'(bus.req_ready), 64'(0));

    // Fairness with everyone valid, including the extreme operand pairs.
    op_a[0] = 16'h7FFF; op_b[0] = 16'h7FFF;
    op_a[1] = 16'h8000; op_b[1] = 16'h8000;
    op_a[2] = 16'($urandom); op_b[2] = 16'($urandom);
    op_a[3] = 16'($urandom); op_b[3] = 16'($urandom);
    pack_ops();
    chk("const_max_prod", 64'(prod(16'h7FFF, 16'h7FFF)), 64'h3FFF0001);
    chk("const_min_prod", 64'(prod(16'h8000, 16'h8000)), 64'h40000000);
    t_prev = 0;
    for (int n = 0; n < 5; n++) begin
      txn(4'b1111, 0, 1'b0, t_now, w);
      chk("rotation_order", 64'(w), 64'(n % NREQ));
      if (n > 0) chk("spacing", 64'(t_now - t_prev), 64'(LAT_OK + 1));
      t_prev = t_now;
    end

    // Single request from requester 2.
    op_a[2] = 16'hFFFD; op_b[2] = 16'h0007;
    pack_ops();
    txn(4'b0100, 0, 1'b0, t_now, w);

    // Backpressure for 10 cycles with spurious done pulses.
    txn(4'b0010, 10, 1'b0, t_now, w);

    // Spurious done while idle in ARB.
    bus.req_valid = '0;
    idle_ok = 1'b1;
    for (int c = 0; c < 4; c++) begin
      spur = ~c[0];
      @(negedge clk); #1;
      if (!(bus.mul_vld === 1'b0 && bus.rsp_valid === 1'b0 && bus.req_ready === '0))
        idle_ok = 1'b0;
    end
    spur = 1'b0;
    chk("spurious_idle", 64'(idle_ok), 64'(1));

    // Watchdog: the stub never completes, then the next request completes normally.
    stub_dead = 1'b1;
    txn(4'b1000, 0, 1'b1, t_now, w);
    stub_dead = 1'b0;
    txn(4'b0001, 0, 1'b0, t_now, w);

    // Randomized traffic and backpressure.
    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if ($urandom_range(0, 3) == 0) op_a[i] = 16'h8000;
        if ($urandom_range(0, 3) == 0) op_b[i] = 16'h7FFF;
      end
      pack_ops();
      txn(4'($urandom_range(1, 15)), int'($urandom_range(0, 3)), 1'b0, t_now, w);
    end

    // Reset in the middle of a run.
    bus.req_valid = 4'b1111;
    #1;
    rr = (pick(4'b1111) + 1) % NREQ;
    repeat (10) @(negedge clk);
    #1;
    rstn = 1'b0;
    #1;
    chk("midrst_mul_vld", 64'(bus.mul_vld), 64'(0));
    chk("midrst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("midrst_req_ready", 64'(bus.req_ready), 64'(0));
    chk("midrst_err_sticky", 64'(err_sticky), 64'(0));
    err_exp = 1'b0;
    rr = 0;
    @(negedge clk); #1;
    rstn = 1'b1;
    #1;
    chk("post_rst_grant0", 64'(bus.req_ready), 64'(1));
    txn(4'b1111, 0, 1'b0, t_now, w);

    bus.req_valid = '0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
